// File: rtl/s1_fetch_pkg.sv
// ----------------------------------------------------------------------------
// s1_fetch_pkg
//   Shared definitions for the stage-1 fetch block: RV32I opcode/funct3
//   fields used to build the canonical NOP, and the fetch FSM state encoding.
// ----------------------------------------------------------------------------
package s1_fetch_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [2:0] F3_ADDI    = 3'b000;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = {12'd0, 5'd0, F3_ADDI, 5'd0, OPC_OP_IMM};

    typedef enum logic {
        ST_BOOT = 1'b0,   // IMEM output not yet valid after reset
        ST_RUN  = 1'b1    // IMEM output holds the word at pc_f
    } fetch_state_e;

endpackage

// File: rtl/s1_pc_gen.sv
// ----------------------------------------------------------------------------
// s1_pc_gen
//   Fetch PC generator: holds pc_f (the PC whose word is on the IMEM output),
//   selects the next fetch PC and flags misaligned redirect targets.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   boot_i          1 while the fetch FSM is in BOOT (re-present pc_f)
//   stall_i         1 = hold the fetch PC
//   redirect_i      1 = next fetch comes from redirect_pc_i
//   redirect_pc_i   redirect target byte address
//   pc_f_o          PC of the word currently on the IMEM output
//   imem_addr_o     IMEM word address derived from the next fetch PC
//   misalign_err_o  sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module s1_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boot_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic [31:0]        pc_f_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic               misalign_err_o
);

    logic [31:0] pc_f_q;
    logic [31:0] pc_next_d;
    logic        misalign_q;
    logic        misalign_d;

    // Redirect wins over stall so that a redirect during a stall is not lost;
    // the low two bits of the target are dropped (word fetch).
    always_comb begin
        pc_next_d = pc_f_q + 32'd4;
        if (redirect_i) begin
            pc_next_d = {redirect_pc_i[31:2], 2'b00};
        end else if (boot_i || stall_i) begin
            pc_next_d = pc_f_q;
        end
    end

    assign misalign_d = misalign_q | (redirect_i & (redirect_pc_i[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q     <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_f_q     <= pc_next_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_f_o         = pc_f_q;
    assign imem_addr_o    = pc_next_d[IMEM_AW+1:2];
    assign misalign_err_o = misalign_q;

endmodule

// File: rtl/s1_fetch.sv
// ----------------------------------------------------------------------------
// s1_fetch
//   Stage-1 fetch/issue. Drives a synchronous 1-cycle IMEM and registers
//   pc/instruction/valid into stage 2. Handles boot, stall (hold) and
//   redirect (squash the wrong-path slot to a NOP bubble).
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   stall           1 = hold s2 outputs and fetch PC
//   redirect        1 = fetch from redirect_pc next; squash current slot
//   redirect_pc     redirect target byte address
//   imem_addr       IMEM word address (combinational)
//   imem_dout       IMEM data for the address presented on the previous edge
//   pc_s2           PC of instruction_s2
//   instruction_s2  instruction into stage 2 (NOP when squashed)
//   valid_s2        1 = instruction_s2 is a real, on-path instruction
//   fetch_count     number of valid instructions delivered to s2
//   misalign_err    sticky: a redirect target had bits[1:0] != 0
// ----------------------------------------------------------------------------
module s1_fetch
    import s1_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        pc_s2,
    output logic [31:0]        instruction_s2,
    output logic               valid_s2,
    output logic [31:0]        fetch_count,
    output logic               misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_s2_q, pc_s2_d;
    logic [31:0]  instr_s2_q, instr_s2_d;
    logic         valid_s2_q, valid_s2_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  pc_f;

    s1_pc_gen #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW)
    ) u_pc_gen (
        .clk            (clk),
        .rst            (rst),
        .boot_i         (state_q == ST_BOOT),
        .stall_i        (stall),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .pc_f_o         (pc_f),
        .imem_addr_o    (imem_addr),
        .misalign_err_o (misalign_err)
    );

    always_comb begin
        state_d       = state_q;
        pc_s2_d       = pc_s2_q;
        instr_s2_d    = instr_s2_q;
        valid_s2_d    = valid_s2_q;
        fetch_count_d = fetch_count_q;
        unique case (state_q)
            ST_BOOT: begin
                // IMEM output is still stale: only a bubble can be issued.
                state_d = ST_RUN;
                if (!stall) begin
                    instr_s2_d = INSTR_NOP;
                    valid_s2_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    // Hold s2; a redirect only retargets pc_f, so no bubble later.
                end else if (redirect) begin
                    // Word on imem_dout is wrong-path: squash it.
                    instr_s2_d = INSTR_NOP;
                    valid_s2_d = 1'b0;
                    pc_s2_d    = pc_f;
                end else begin
                    instr_s2_d    = imem_dout;
                    pc_s2_d       = pc_f;
                    valid_s2_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_s2_q       <= RESET_PC;
            instr_s2_q    <= INSTR_NOP;
            valid_s2_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_s2_q       <= pc_s2_d;
            instr_s2_q    <= instr_s2_d;
            valid_s2_q    <= valid_s2_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc_s2          = pc_s2_q;
    assign instruction_s2 = instr_s2_q;
    assign valid_s2       = valid_s2_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_s1_fetch.sv
// ----------------------------------------------------------------------------
// tb_s1_fetch
//   Directed bench for s1_fetch with a synchronous IMEM model.
//   IMEM word at index 0 is 0x00500093; every other index i holds
//   0xABC0_0000 | i, so expected instructions follow from the PC by hand.
// ----------------------------------------------------------------------------
module tb_s1_fetch;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam int          IMEM_AW  = 14;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stall = 1'b0;
    logic               redirect = 1'b0;
    logic [31:0]        redirect_pc = 32'd0;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_dout = 32'd0;
    logic [31:0]        pc_s2;
    logic [31:0]        instruction_s2;
    logic               valid_s2;
    logic [31:0]        fetch_count;
    logic               misalign_err;

    int total = 0;
    int bad   = 0;

    s1_fetch #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .pc_s2          (pc_s2),
        .instruction_s2 (instruction_s2),
        .valid_s2       (valid_s2),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [IMEM_AW-1:0] a);
        if (a == '0) return 32'h0050_0093;
        return 32'hABC0_0000 | {{(32-IMEM_AW){1'b0}}, a};
    endfunction

    always @(posedge clk) imem_dout <= imem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_s2(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic vld, input logic [31:0] cnt);
        chk({tag, ".pc"},    pc_s2,                 pc);
        chk({tag, ".instr"}, instruction_s2,        ins);
        chk({tag, ".valid"}, {31'd0, valid_s2},     {31'd0, vld});
        chk({tag, ".count"}, fetch_count,           cnt);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_s2(tag, RESET_PC, NOP, 1'b0, 32'd0);
        chk({tag, ".mis"}, {31'd0, misalign_err}, 32'd0);
    endtask

    task automatic boot_seq(input string tag);
        @(negedge clk);
        rst = 1'b0;
        tick();  // edge 1: bubble
        chk_s2({tag, ".e1"}, RESET_PC, NOP, 1'b0, 32'd0);
        tick();  // edge 2: first instruction
        chk_s2({tag, ".e2"}, 32'h4000_0000, 32'h0050_0093, 1'b1, 32'd1);
        tick();  // edge 3
        chk_s2({tag, ".e3"}, 32'h4000_0004, 32'hABC0_0001, 1'b1, 32'd2);
    endtask

    initial begin
        // Reset state
        #12;
        chk_reset_state("rst");
        chk("rst.addr", {18'd0, imem_addr}, 32'd0);

        // Test 1: boot
        boot_seq("boot");

        // Test 2: stall 3 cycles (pc_f = 0x4000_0008)
        stall = 1'b1;
        #1;
        chk("stall.addr0", {18'd0, imem_addr}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_s2("stall", 32'h4000_0004, 32'hABC0_0001, 1'b1, 32'd2);
            chk("stall.addr", {18'd0, imem_addr}, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk_s2("unstall", 32'h4000_0008, 32'hABC0_0002, 1'b1, 32'd3);

        // Test 3: redirect one cycle (pc_f = 0x4000_000C)
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0100;
        #1;
        chk("redir.addr", {18'd0, imem_addr}, 32'h40);
        tick();
        chk_s2("redir.bubble", 32'h4000_000C, NOP, 1'b0, 32'd3);
        redirect = 1'b0;
        tick();
        chk_s2("redir.tgt", 32'h4000_0100, 32'hABC0_0040, 1'b1, 32'd4);
        chk("redir.mis", {31'd0, misalign_err}, 32'd0);

        // Test 4: redirect + stall in the same cycle, then release
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0200;
        tick();
        chk_s2("rs.hold", 32'h4000_0100, 32'hABC0_0040, 1'b1, 32'd4);
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        chk_s2("rs.tgt", 32'h4000_0200, 32'hABC0_0080, 1'b1, 32'd5);

        // Multi-cycle stall+redirect: last target wins, no bubble
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0300;
        tick();
        redirect_pc = 32'h4000_0400;
        tick();
        chk_s2("rs2.hold", 32'h4000_0200, 32'hABC0_0080, 1'b1, 32'd5);
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        chk_s2("rs2.tgt", 32'h4000_0400, 32'hABC0_0100, 1'b1, 32'd6);

        // Test 5: misaligned redirect target (pc_f = 0x4000_0404)
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0102;
        #1;
        chk("mis.addr", {18'd0, imem_addr}, 32'h40);
        tick();
        chk("mis.set", {31'd0, misalign_err}, 32'd1);
        chk_s2("mis.bubble", 32'h4000_0404, NOP, 1'b0, 32'd6);
        redirect = 1'b0;
        tick();
        chk_s2("mis.tgt", 32'h4000_0100, 32'hABC0_0040, 1'b1, 32'd7);
        tick();
        tick();
        chk("mis.sticky", {31'd0, misalign_err}, 32'd1);
        chk_s2("mis.run", 32'h4000_0108, 32'hABC0_0042, 1'b1, 32'd9);

        // Test 6: asynchronous reset between edges, boot repeats
        #3;
        rst = 1'b1;
        #1;
        chk_reset_state("arst");
        boot_seq("reboot");

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap.addr", {18'd0, imem_addr}, 32'h3FFF);
        tick();
        redirect = 1'b0;
        tick();
        chk_s2("wrap.top", 32'hFFFF_FFFC, 32'hABC0_3FFF, 1'b1, 32'd3);
        tick();
        chk_s2("wrap.zero", 32'h0000_0000, 32'h0050_0093, 1'b1, 32'd4);
        chk("wrap.mis", {31'd0, misalign_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
